dom1_skinny_fpga_host: RTL and testbench
========================================

DOM1_SKINNY_FPGA_HOST -- requirements
Module: dom1_skinny_fpga_host

Interface
REQ-001 Parameter NBYTES, default 112, SHALL set the payload bytes sent and result bytes collected per run.
REQ-002 Parameter CMD_BYTE, default 8'h01, SHALL set the start-of-load command byte.
REQ-003 Parameter TIMEOUT, default 65535, SHALL set the maximum idle cycles allowed in RECV (16-bit counter).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  payload buffer write strobe
- wr_addr  in  7  payload buffer address, 0..NBYTES-1
- wr_data  in  8  payload byte
- start  in  1  single-cycle run request
- rd_addr  in  7  result buffer address
- rd_data  out  8  result byte, registered
- busy  out  1  run in progress
- done  out  1  last run completed, sticky
- timeout  out  1  last run aborted in RECV, sticky
- tx_data  out  8  byte to core-side di_data
- tx_valid  out  1  to core-side di_valid
- tx_ready  in  1  from core-side di_ready
- rx_data  in  8  byte from core-side output
- rx_valid  in  1  from core-side do_valid
- rx_ready  out  1  to core-side do_ready

Function
REQ-006 States SHALL be IDLE, CMD, SEND, RECV; busy=1 in every state except IDLE.
REQ-007 Payload buffer SHALL be NBYTES x 8, written at the clock edge when wr_en=1 and state=IDLE; writes in other states are ignored; addresses >= NBYTES are ignored.
REQ-008 IDLE with start=1 SHALL: go to CMD, clear done and timeout, and clear the byte counter to 0; start in other states is ignored.
REQ-009 A wr_en and start in the same IDLE cycle SHALL both take effect; the written byte is transmitted in that run.
REQ-010 CMD SHALL drive tx_valid=1 and tx_data=CMD_BYTE; on tx_valid&tx_ready it SHALL go to SEND with counter=0.
REQ-011 SEND SHALL drive tx_valid=1 and tx_data=payload[counter] combinationally from the counter.
- on tx_ready: counter+1.
- on tx_ready with counter=NBYTES-1: counter=0, go to RECV.
- Bytes leave back-to-back, one per cycle, while tx_ready=1.
REQ-012 tx_valid SHALL be 0 and tx_data SHALL be 8'h00 in IDLE and RECV.
REQ-013 RECV SHALL drive rx_ready=1; rx_ready SHALL be 0 in all other states; rx_valid outside RECV is ignored.
REQ-014 In RECV, each rx_valid&rx_ready cycle SHALL write rx_data to result[counter] and increment the counter.
- on the capture with counter=NBYTES-1: go to IDLE and set done=1.
REQ-015 A 16-bit idle counter SHALL clear on entry to RECV and on every capture, and increment on each RECV cycle without rx_valid.
- on reaching TIMEOUT: go to IDLE, set timeout=1, leave done=0.
- Result bytes captured so far are retained.
REQ-016 rd_data SHALL equal result[rd_addr] one cycle after rd_addr is presented, in any state; out-of-range rd_addr returns 8'h00.
REQ-017 The byte counter SHALL be 7 bits and never exceed NBYTES-1; the idle counter SHALL saturate at TIMEOUT.
REQ-018 Latency from start to the first tx byte SHALL be 1 cycle (CMD presented in the cycle after start).
REQ-019 Minimum run time with tx_ready=rx_valid=1 constant SHALL be 1+1+NBYTES+NBYTES cycles from start to done.

Reset
REQ-020 rst=1 SHALL immediately force state=IDLE, counters=0, busy=0, done=0, timeout=0, tx_valid=0, tx_data=0, rx_ready=0, rd_data=0, regardless of the clock.
REQ-021 Reset SHALL NOT clear the payload or result buffer contents.
REQ-022 Reset asserted mid-run SHALL abort the run; after release the block SHALL accept a new start with no residual state.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Load payload[i]=i, start, core model with tx_ready=1 and rx_valid=1 with rx_data=i^8'hA5 -> tx sequence 01,00..6F back-to-back; result[i]=i^A5; done=1 at cycle 226 after start.
- tx_ready low 3 cycles during CMD and at byte 50 -> tx_data holds 01 and then 32 until ready; no byte is skipped or duplicated.
- rx_valid toggling 1/0 -> exactly 112 captures, done=1, rx_ready=1 only in RECV.
- TIMEOUT=20 and rx_valid stuck at 0 after 5 bytes -> timeout=1 at cycle 20 of idle, done=0, busy=0, result[0..4] intact.
- Start during busy and wr_en during SEND -> ignored; payload unchanged and the run is unaffected.
- rst pulse at SEND byte 40 -> outputs zero asynchronously; a new start replays the full sequence beginning with 01.

Source files
------------

// File: rtl/dom1_skinny_fpga_host.sv
`default_nettype none
// =============================================================================
// dom1_skinny_fpga_host: streams a command byte and NBYTES payload bytes to a
// byte-serial core, then collects NBYTES result bytes with an idle timeout.
// Revision: 1.0
// =============================================================================
module dom1_skinny_fpga_host #(
  parameter int         NBYTES   = 112,
  parameter logic [7:0] CMD_BYTE = 8'h01,
  parameter int         TIMEOUT  = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam logic [6:0]  c_LAST_IDX = 7'(NBYTES - 1);
  localparam logic [7:0]  c_NB       = 8'(NBYTES);
  localparam logic [15:0] c_TO       = 16'(TIMEOUT);
  localparam logic [15:0] c_TO_M1    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_SEND = 2'd2,
    S_RECV = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;
  logic        done_q, done_d;
  logic        to_q, to_d;
  logic [7:0]  rd_q;
  logic        w_pay_we;
  logic        w_res_we;

  logic [7:0] pay_q [NBYTES];
  logic [7:0] res_q [NBYTES];

  assign w_pay_we = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < c_NB);
  assign w_res_we = (state_q == S_RECV) && rx_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    done_d   = done_q;
    to_d     = to_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CMD;
          cnt_d   = '0;
          done_d  = 1'b0;
          to_d    = 1'b0;
        end
      end
      S_CMD: begin
        tx_valid = 1'b1;
        tx_data  = CMD_BYTE;
        if (tx_ready) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = pay_q[cnt_q];
        if (tx_ready) begin
          if (cnt_q == c_LAST_IDX) begin
            state_d = S_RECV;
            cnt_d   = '0;
            idle_d  = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      S_RECV: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          idle_d = '0;
          if (cnt_q == c_LAST_IDX) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end else if (idle_q >= c_TO_M1) begin
          // Captured bytes stay in the result buffer; only the run is abandoned.
          state_d = S_IDLE;
          idle_d  = c_TO;
          to_d    = 1'b1;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      to_q    <= to_d;
      rd_q    <= ({1'b0, rd_addr} < c_NB) ? res_q[rd_addr] : 8'h00;
    end
  end

  // Buffers are deliberately left out of reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (w_pay_we) pay_q[wr_addr] <= wr_data;
    if (w_res_we) res_q[cnt_q]   <= rx_data;
  end

  assign rd_data = rd_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign timeout = to_q;

endmodule
`default_nettype wire

// File: tb/tb_dom1_skinny_fpga_host.sv
`default_nettype none
// tb_dom1_skinny_fpga_host: table of run scenarios checked against a
// transaction-level model of the host (byte queue out, result array in).
module tb_dom1_skinny_fpga_host;

  localparam int         NB  = 112;
  localparam int         TO  = 20;
  localparam logic [7:0] CMD = 8'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, start, tx_ready, rx_valid;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rx_data;
  logic [7:0] rd_data, tx_data;
  logic       busy, done, timeout, tx_valid, rx_ready;

  always #5 clk = ~clk;

  dom1_skinny_fpga_host #(.NBYTES(NB), .CMD_BYTE(CMD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .done(done), .timeout(timeout), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  int nchk = 0;
  int nerr = 0;
  logic [7:0] pay_m [NB];
  logic [7:0] res_m [NB];

  // ld: 0 payload=i, 1 random, 2 keep. rmode: 0 ready, 1 random, 2 stalls.
  // vmode: 0 valid, 1 toggle, 2 random, 3 stop after 5 captures.
  typedef struct {
    int ld; int rmode; int vmode; bit xorpat; bit inj; bit sw;
    bit exp_done; bit exp_to; int exp_cyc;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic load(input int mode);
    if (mode == 2) return;
    for (int i = 0; i < NB; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 7'(i);
      wr_data = (mode == 0) ? 8'(i) : 8'($urandom);
      pay_m[i] = wr_data;
    end
    @(posedge clk); #1;
    wr_addr = 7'd127; wr_data = 8'hFF;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic readback(input string nm);
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1 rd_addr = 7'(i);
      @(posedge clk); #1;
      chk(nm, {24'd0, rd_data}, (i < NB) ? {24'd0, res_m[i]} : 32'd0);
    end
  endtask

  task automatic do_run(input vec_t v);
    logic [7:0] exq [$];
    int txi = 0, capi = 0, idle = 0, cyc = 1, stallc = 0;
    bit fin = 1'b0, rph;
    @(posedge clk); #1;
    start = 1'b1;
    if (v.sw) begin
      wr_en = 1'b1; wr_addr = 7'($urandom_range(0, NB - 1)); wr_data = 8'($urandom);
      pay_m[wr_addr] = wr_data;
    end
    exq.push_back(CMD);
    for (int i = 0; i < NB; i++) exq.push_back(pay_m[i]);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    while (!fin) begin
      case (v.rmode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          tx_ready = 1'b1;
          if ((txi == 0 || txi == 51) && stallc < 3) begin
            tx_ready = 1'b0; stallc++;
          end
        end
      endcase
      case (v.vmode)
        0: rx_valid = 1'b1;
        1: rx_valid = 1'(cyc % 2);
        2: rx_valid = ($urandom_range(0, 3) != 0);
        default: rx_valid = (capi < 5);
      endcase
      rx_data = v.xorpat ? (8'(capi) ^ 8'hA5) : 8'($urandom);
      if (v.inj) begin
        start = 1'($urandom_range(0, 1));
        wr_en = 1'($urandom_range(0, 1));
        wr_addr = 7'($urandom_range(0, NB - 1)); wr_data = 8'($urandom);
      end
      rph = (txi == NB + 1);
      @(negedge clk);
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, !rph});
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, rph});
      chk("tx_data", {24'd0, tx_data}, rph ? 32'd0 : {24'd0, exq[txi]});
      if (!rph) begin
        if (tx_ready) begin txi++; stallc = 0; end
      end else if (rx_valid) begin
        res_m[capi] = rx_data; capi++; idle = 0;
        if (capi == NB) fin = 1'b1;
      end else begin
        idle++;
        if (idle == TO) fin = 1'b1;
      end
      if (cyc > 2000) begin
        chk("run_budget", 32'(cyc), 32'd2000);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    @(posedge clk); #1;
    cyc++;
    start = 1'b0; wr_en = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("done_end", {31'd0, done}, {31'd0, v.exp_done});
    chk("timeout_end", {31'd0, timeout}, {31'd0, v.exp_to});
    chk("txv_end", {31'd0, tx_valid | rx_ready}, 32'd0);
    if (v.exp_cyc > 0) chk("end_cycle", 32'(cyc), 32'(v.exp_cyc));
  endtask

  task automatic apply(input vec_t v);
    load(v.ld);
    do_run(v);
    readback("result_rd");
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  {31'd0, busy}, 32'd0);
    chk({nm, "_done"},  {31'd0, done}, 32'd0);
    chk({nm, "_to"},    {31'd0, timeout}, 32'd0);
    chk({nm, "_txv"},   {31'd0, tx_valid}, 32'd0);
    chk({nm, "_txd"},   {24'd0, tx_data}, 32'd0);
    chk({nm, "_rxr"},   {31'd0, rx_ready}, 32'd0);
    chk({nm, "_rdd"},   {24'd0, rd_data}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{ld:0, rmode:0, vmode:0, xorpat:1, inj:0, sw:0, exp_done:1, exp_to:0, exp_cyc:226};
    vecs[1] = '{ld:1, rmode:2, vmode:0, xorpat:0, inj:0, sw:0, exp_done:1, exp_to:0, exp_cyc:232};
    vecs[2] = '{ld:1, rmode:0, vmode:1, xorpat:0, inj:0, sw:0, exp_done:1, exp_to:0, exp_cyc:-1};
    vecs[3] = '{ld:1, rmode:0, vmode:3, xorpat:0, inj:0, sw:0, exp_done:0, exp_to:1, exp_cyc:139};
    vecs[4] = '{ld:1, rmode:1, vmode:2, xorpat:0, inj:1, sw:1, exp_done:1, exp_to:0, exp_cyc:-1};
    vecs[5] = '{ld:2, rmode:1, vmode:2, xorpat:0, inj:0, sw:0, exp_done:1, exp_to:0, exp_cyc:-1};

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rx_data = '0;
    #3;
    chk_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) apply(vecs[k]);

    // Asynchronous reset while byte 40 is on the bus.
    load(1);
    rd_addr = 7'd3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; tx_ready = 1'b1;
    repeat (41) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_txd", {24'd0, tx_data}, {24'd0, pay_m[40]});
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b0;
    readback("kept_rd");
    apply(vecs[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
